sva_verdict_collector: RTL and testbench
========================================

Name: sva_verdict_collector

Overview:
Downstream consumer of the per-assertion FSM checker. Once per gclk cycle it takes that cycle's aggregated checker result (success, fail, lazy success, plus the start period of the attempt) and keeps saturating tallies. It captures the first failure and buffers every failing start period in a small FIFO for a testbench or logger to drain. At end of test it produces a single registered verdict.

Parameters:
TIMER_WIDTH, 8, width of the attempt start-period stamp; matches the checker timer.
CNT_WIDTH, 16, width of each saturating result counter.
LOG_DEPTH, 8, fail-log FIFO depth; must be a power of 2 and at least 2.

Ports:
- gclk  in  1  user clock; all logic is rising-edge.
- grst  in  1  asynchronous, active-high reset.
- enable  in  1  start collecting (level).
- res_valid  in  1  result bundle valid this cycle.
- res_succ  in  1  an attempt completed successfully.
- res_fail  in  1  an attempt failed.
- res_lazy  in  1  an attempt reached lazy success.
- res_period  in  TIMER_WIDTH  start period of the reported attempt.
- eot  in  1  end-of-test strobe.
- log_ready  in  1  consumer pops the fail log.
- log_valid  out  1  fail-log head is valid.
- log_period  out  TIMER_WIDTH  fail-log head value.
- log_overflow  out  1  sticky; a failure was dropped because the log was full.
- proto_err  out  1  sticky; res_succ and res_fail were both set in one bundle.
- succ_cnt, fail_cnt, lazy_cnt  out  CNT_WIDTH  saturating tallies.
- first_fail_valid  out  1  a failure has been captured.
- first_fail_period  out  TIMER_WIDTH  res_period of the first failure.
- state  out  2  IDLE=0, RUN=1, DONE=2.
- verdict_valid  out  1  one-cycle pulse.
- verdict  out  2  PASS=00, FAIL=01, VACUOUS=10.

Behaviour:
- **Reset:** grst (async) forces state=IDLE and clears all counters, sticky flags, FIFO pointers, log_valid, first_fail_*, verdict_valid and verdict to 0. Reset mid-operation discards everything.
- **IDLE:** inputs are ignored. enable=1 moves to RUN at the next edge and clears all counters, stickies, first_fail and the FIFO on that edge.
- **RUN:** results are accepted when res_valid=1.
  - The three counters update independently, each +1 per asserted flag, saturating at all-ones (no wrap).
  - res_succ&res_fail in the same bundle: both counters update and proto_err sets.
  - First failure: first_fail_period latches res_period and first_fail_valid sets; later failures do not overwrite it.
  - eot=1 moves to DONE. A result valid in the eot cycle is still counted.
  - enable=0 in RUN moves to IDLE with no verdict.
- **DONE:**
  - verdict_valid pulses high in the first DONE cycle only.
  - Verdict is computed from the registered counts: fail_cnt>0 gives FAIL; else succ_cnt+lazy_cnt>0 gives PASS; else VACUOUS. verdict holds until the next RUN entry.
  - Results are ignored in DONE.
  - enable=0 moves to IDLE; counts stay visible until the next RUN entry.
- **Fail log (synchronous FIFO, LOG_DEPTH entries):**
  - Push condition: RUN & res_valid & res_fail, with res_period as the data.
  - Pop condition: log_valid & log_ready.
  - Latency: a push into an empty FIFO gives log_valid=1 on the next cycle. log_period is the registered head, in first-in first-out order.
  - Full with push and no pop: the push is dropped and log_overflow sets. fail_cnt still increments.
  - Full with push and pop in the same cycle: both occur and occupancy is unchanged.
  - Empty: pop is ignored.
  - Pointers wrap modulo LOG_DEPTH, with one extra bit to distinguish full from empty.
  - The FIFO stays drainable in IDLE and DONE.

Optional Feature:
SVA_STOP_ON_FAIL_EN
- **Defined:** the first accepted failure in RUN forces the next state to DONE, as if eot had been asserted. The failing bundle itself is fully counted and logged, and verdict=FAIL.
- **Undefined:** failures never change state.

Test Plan:
- Reset, enable=1, four bundles with res_succ=1, then eot -> succ_cnt=4, fail_cnt=0, verdict_valid pulses one cycle after eot, verdict=00.
- enable=1, eot with no results -> verdict=10, all counters 0.
- Failures with res_period 3, 7, 9, log_ready=0 -> first_fail_period=3; log drains 3, 7, 9 in order; fail_cnt=3, verdict=01.
- LOG_DEPTH=8, 10 failures with log_ready=0 -> log holds the first 8, log_overflow=1, fail_cnt=10. Then a push and a pop in the same full cycle -> occupancy stays 8, no new overflow.
- One bundle with res_succ=res_fail=1 -> proto_err=1, both counters +1. CNT_WIDTH=4 with 20 successes -> succ_cnt=15.
- With SVA_STOP_ON_FAIL_EN, a failure at cycle 5 followed by successes -> state=DONE at cycle 6, later successes are not counted, verdict=01. Asserting grst mid-RUN clears all outputs immediately.

Source files
------------

// File: rtl/sva_verdict_collector_if.sv
// Result-bundle and fail-log signals between the per-assertion checker, the
// verdict collector and whatever drains the log.
interface sva_verdict_collector_if #(
    parameter int TIMER_WIDTH = 8
);
    logic                   res_valid;
    logic                   res_succ;
    logic                   res_fail;
    logic                   res_lazy;
    logic [TIMER_WIDTH-1:0] res_period;
    logic                   log_ready;
    logic                   log_valid;
    logic [TIMER_WIDTH-1:0] log_period;

    modport master (
        output res_valid, res_succ, res_fail, res_lazy, res_period, log_ready,
        input  log_valid, log_period
    );

    modport slave (
        input  res_valid, res_succ, res_fail, res_lazy, res_period, log_ready,
        output log_valid, log_period
    );
endinterface

// File: rtl/sva_verdict_collector.sv
// Tallies per-cycle assertion results, logs failing start periods and issues one
// end-of-test verdict. Define SVA_STOP_ON_FAIL_EN to end the run on the first failure.
module sva_verdict_collector #(
    parameter int TIMER_WIDTH = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int LOG_DEPTH   = 8
) (
    input  logic                   gclk,
    input  logic                   grst,
    input  logic                   enable,
    input  logic                   eot,
    sva_verdict_collector_if.slave bus,
    output logic                   log_overflow,
    output logic                   proto_err,
    output logic [CNT_WIDTH-1:0]   succ_cnt,
    output logic [CNT_WIDTH-1:0]   fail_cnt,
    output logic [CNT_WIDTH-1:0]   lazy_cnt,
    output logic                   first_fail_valid,
    output logic [TIMER_WIDTH-1:0] first_fail_period,
    output logic [1:0]             state,
    output logic                   verdict_valid,
    output logic [1:0]             verdict
);
    // state | meaning
    // IDLE  | results ignored, counts from the last run stay visible
    // RUN   | results accepted and tallied
    // DONE  | run over, verdict issued and held
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam int         AW     = $clog2(LOG_DEPTH);
    localparam logic [1:0] V_PASS = 2'b00;
    localparam logic [1:0] V_FAIL = 2'b01;
    localparam logic [1:0] V_VAC  = 2'b10;

    state_t                 st_q, st_d;
    logic                   run_entry, accept, fail_acc, stop_hit, done_entry;
    logic [CNT_WIDTH-1:0]   succ_nx, fail_nx, lazy_nx;
    logic [1:0]             verdict_nx;
    logic [AW:0]            wr_ptr, rd_ptr;
    logic [TIMER_WIDTH-1:0] mem [LOG_DEPTH];
    logic                   fifo_full, push, pop, push_ok;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c,
                                                     input logic hit);
        return (hit && (c != '1)) ? c + 1'b1 : c;
    endfunction

    assign run_entry = (st_q == IDLE) && enable;
    assign accept    = (st_q == RUN) && bus.res_valid;
    assign fail_acc  = accept && bus.res_fail;

`ifdef SVA_STOP_ON_FAIL_EN
    assign stop_hit = fail_acc;
`else
    assign stop_hit = 1'b0;
`endif

    always_comb begin
        st_d = st_q;
        case (st_q)
            IDLE:    if (enable) st_d = RUN;
            RUN:     if (!enable) st_d = IDLE;
                     else if (eot || stop_hit) st_d = DONE;
            DONE:    if (!enable) st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    assign done_entry = (st_q == RUN) && (st_d == DONE);

    assign succ_nx = sat_inc(succ_cnt, accept && bus.res_succ);
    assign fail_nx = sat_inc(fail_cnt, accept && bus.res_fail);
    assign lazy_nx = sat_inc(lazy_cnt, accept && bus.res_lazy);

    // Verdict is taken from the post-update counts so a result in the eot
    // cycle (or the stopping failure) is reflected.
    always_comb begin
        verdict_nx = V_VAC;
        if (fail_nx != '0)
            verdict_nx = V_FAIL;
        else if ((succ_nx != '0) || (lazy_nx != '0))
            verdict_nx = V_PASS;
    end

    assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push      = fail_acc;
    assign pop       = bus.log_valid && bus.log_ready;
    assign push_ok   = push && (!fifo_full || pop);

    assign bus.log_valid  = (wr_ptr != rd_ptr);
    assign bus.log_period = bus.log_valid ? mem[rd_ptr[AW-1:0]] : '0;
    assign state          = st_q;

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            st_q              <= IDLE;
            succ_cnt          <= '0;
            fail_cnt          <= '0;
            lazy_cnt          <= '0;
            proto_err         <= 1'b0;
            log_overflow      <= 1'b0;
            first_fail_valid  <= 1'b0;
            first_fail_period <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            verdict_valid     <= 1'b0;
            verdict           <= V_PASS;
        end else begin
            st_q          <= st_d;
            verdict_valid <= done_entry;
            if (run_entry) begin
                succ_cnt          <= '0;
                fail_cnt          <= '0;
                lazy_cnt          <= '0;
                proto_err         <= 1'b0;
                log_overflow      <= 1'b0;
                first_fail_valid  <= 1'b0;
                first_fail_period <= '0;
                wr_ptr            <= '0;
                rd_ptr            <= '0;
                verdict           <= V_PASS;
            end else begin
                succ_cnt <= succ_nx;
                fail_cnt <= fail_nx;
                lazy_cnt <= lazy_nx;
                if (accept && bus.res_succ && bus.res_fail)
                    proto_err <= 1'b1;
                if (fail_acc && !first_fail_valid) begin
                    first_fail_valid  <= 1'b1;
                    first_fail_period <= bus.res_period;
                end
                if (push && fifo_full && !pop)
                    log_overflow <= 1'b1;
                if (push_ok)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (done_entry)
                    verdict <= verdict_nx;
            end
        end
    end

    // Storage needs no reset; pointers alone define what is valid.
    always_ff @(posedge gclk) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= bus.res_period;
    end
endmodule

// File: tb/tb_sva_verdict_collector.sv
// Bench for sva_verdict_collector: vector table, directed corner sequences and
// random traffic checked against a queue-based behavioural model.
module tb_sva_verdict_collector;
    localparam int TW = 8;
    localparam int LD = 8;
`ifdef SVA_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic gclk, grst, enable, eot;
    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    sva_verdict_collector_if #(.TIMER_WIDTH(TW)) bus ();
    sva_verdict_collector_if #(.TIMER_WIDTH(TW)) bus4 ();
    assign bus4.res_valid  = bus.res_valid;
    assign bus4.res_succ   = bus.res_succ;
    assign bus4.res_fail   = bus.res_fail;
    assign bus4.res_lazy   = bus.res_lazy;
    assign bus4.res_period = bus.res_period;
    assign bus4.log_ready  = bus.log_ready;

    logic          log_overflow, proto_err, first_fail_valid, verdict_valid;
    logic [15:0]   succ_cnt, fail_cnt, lazy_cnt;
    logic [TW-1:0] first_fail_period;
    logic [1:0]    state, verdict;
    logic          log_overflow4, proto_err4, first_fail_valid4, verdict_valid4;
    logic [3:0]    succ_cnt4, fail_cnt4, lazy_cnt4;
    logic [TW-1:0] first_fail_period4;
    logic [1:0]    state4, verdict4;

    sva_verdict_collector #(.TIMER_WIDTH(TW), .CNT_WIDTH(16), .LOG_DEPTH(LD)) dut (
        .gclk(gclk), .grst(grst), .enable(enable), .eot(eot), .bus(bus),
        .log_overflow(log_overflow), .proto_err(proto_err),
        .succ_cnt(succ_cnt), .fail_cnt(fail_cnt), .lazy_cnt(lazy_cnt),
        .first_fail_valid(first_fail_valid), .first_fail_period(first_fail_period),
        .state(state), .verdict_valid(verdict_valid), .verdict(verdict)
    );

    sva_verdict_collector #(.TIMER_WIDTH(TW), .CNT_WIDTH(4), .LOG_DEPTH(LD)) dut4 (
        .gclk(gclk), .grst(grst), .enable(enable), .eot(eot), .bus(bus4),
        .log_overflow(log_overflow4), .proto_err(proto_err4),
        .succ_cnt(succ_cnt4), .fail_cnt(fail_cnt4), .lazy_cnt(lazy_cnt4),
        .first_fail_valid(first_fail_valid4), .first_fail_period(first_fail_period4),
        .state(state4), .verdict_valid(verdict_valid4), .verdict(verdict4)
    );

    // Behavioural model: unbounded counts, FIFO as a queue.
    int            m_state, m_succ, m_fail, m_lazy;
    bit            m_ffv, m_proto, m_ovf, m_vv;
    logic [TW-1:0] m_ffp;
    logic [1:0]    m_verdict;
    logic [TW-1:0] m_q[$];
    int            checks, errors;

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_succ = 0; m_fail = 0; m_lazy = 0;
        m_ffv = 0; m_ffp = '0; m_proto = 0; m_ovf = 0; m_vv = 0; m_verdict = 2'b00;
        m_q.delete();
    endtask

    task automatic model_step();
        bit acc, pop, was_full;
        m_vv     = 0;
        acc      = (m_state == 1) && bus.res_valid;
        pop      = (m_q.size() > 0) && bus.log_ready;
        was_full = (m_q.size() == LD);
        if (m_state == 0 && enable) begin
            model_reset();
            m_state = 1;
            return;
        end
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            if (bus.res_succ) m_succ++;
            if (bus.res_fail) m_fail++;
            if (bus.res_lazy) m_lazy++;
            if (bus.res_succ && bus.res_fail) m_proto = 1;
            if (bus.res_fail) begin
                if (!m_ffv) begin m_ffv = 1; m_ffp = bus.res_period; end
                if (was_full && !pop) m_ovf = 1;
                else m_q.push_back(bus.res_period);
            end
        end
        if (m_state == 1) begin
            if (!enable) m_state = 0;
            else if (eot || (STOP && acc && bus.res_fail)) begin
                m_state = 2;
                m_vv = 1;
                m_verdict = (m_fail > 0) ? 2'b01 : ((m_succ + m_lazy > 0) ? 2'b00 : 2'b10);
            end
        end else if (m_state == 2) begin
            if (!enable) m_state = 0;
        end
    endtask

    task automatic check_all();
        chk("state", state, m_state);
        chk("succ_cnt", succ_cnt, sat(m_succ, 16));
        chk("fail_cnt", fail_cnt, sat(m_fail, 16));
        chk("lazy_cnt", lazy_cnt, sat(m_lazy, 16));
        chk("first_fail_valid", first_fail_valid, m_ffv);
        chk("first_fail_period", first_fail_period, m_ffp);
        chk("proto_err", proto_err, m_proto);
        chk("log_overflow", log_overflow, m_ovf);
        chk("log_valid", bus.log_valid, m_q.size() > 0);
        if (m_q.size() > 0) chk("log_period", bus.log_period, m_q[0]);
        chk("verdict_valid", verdict_valid, m_vv);
        chk("verdict", verdict, m_verdict);
        chk("w4.state", state4, m_state);
        chk("w4.succ_cnt", succ_cnt4, sat(m_succ, 4));
        chk("w4.fail_cnt", fail_cnt4, sat(m_fail, 4));
        chk("w4.lazy_cnt", lazy_cnt4, sat(m_lazy, 4));
        chk("w4.first_fail", {first_fail_valid4, first_fail_period4}, {m_ffv, m_ffp});
        chk("w4.flags", {proto_err4, log_overflow4, bus4.log_valid}, {m_proto, m_ovf, m_q.size() > 0});
        if (m_q.size() > 0) chk("w4.log_period", bus4.log_period, m_q[0]);
        chk("w4.verdict", {verdict_valid4, verdict4}, {m_vv, m_verdict});
    endtask

    task automatic step();
        @(posedge gclk);
        if (grst) model_reset(); else model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input bit en, input bit rv, input bit s, input bit f, input bit l,
                         input logic [TW-1:0] per, input bit e, input bit rdy);
        enable = en; bus.res_valid = rv; bus.res_succ = s; bus.res_fail = f;
        bus.res_lazy = l; bus.res_period = per; eot = e; bus.log_ready = rdy;
    endtask

    typedef struct {
        bit en, rv, s, f, l, e, rdy;
        logic [TW-1:0] per;
        int exp_state, exp_succ, exp_fail;
        bit exp_vv;
        logic [1:0] exp_verdict;
    } vec_t;
    vec_t vt[16];

    logic [TW-1:0] exp_log[$];
    int n;

    initial begin
        checks = 0; errors = 0;
        model_reset();
        grst = 1'b1;
        drive(0, 0, 0, 0, 0, '0, 0, 0);

        //        en rv s f l e rdy per    st succ fail vv verdict
        vt[0]  = '{1, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 2'b00};
        vt[1]  = '{1, 1, 1, 0, 0, 0, 0, 8'h01, 1, 1, 0, 0, 2'b00};
        vt[2]  = '{1, 1, 1, 0, 0, 0, 0, 8'h02, 1, 2, 0, 0, 2'b00};
        vt[3]  = '{1, 1, 1, 0, 0, 0, 0, 8'h03, 1, 3, 0, 0, 2'b00};
        vt[4]  = '{1, 1, 1, 0, 0, 0, 0, 8'h04, 1, 4, 0, 0, 2'b00};
        vt[5]  = '{1, 0, 0, 0, 0, 1, 0, 8'h00, 2, 4, 0, 1, 2'b00};
        vt[6]  = '{1, 0, 0, 0, 0, 0, 0, 8'h00, 2, 4, 0, 0, 2'b00};
        vt[7]  = '{0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 4, 0, 0, 2'b00};
        vt[8]  = '{1, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 2'b00};
        vt[9]  = '{1, 0, 0, 0, 0, 1, 0, 8'h00, 2, 0, 0, 1, 2'b10};
        vt[10] = '{1, 0, 0, 0, 0, 0, 0, 8'h00, 2, 0, 0, 0, 2'b10};
        vt[11] = '{0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 2'b10};
        vt[12] = '{1, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 2'b00};
        vt[13] = '{1, 1, 0, 0, 1, 1, 0, 8'h00, 2, 0, 0, 1, 2'b00};
        vt[14] = '{0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 2'b00};
        vt[15] = '{0, 1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 2'b00};

        step();
        chk("rst.state", state, 0);
        chk("rst.counts", {succ_cnt, fail_cnt, lazy_cnt}, 0);
        chk("rst.flags", {log_overflow, proto_err, first_fail_valid, bus.log_valid, verdict_valid, verdict}, 0);
        step();
        grst = 1'b0;

        foreach (vt[i]) begin
            drive(vt[i].en, vt[i].rv, vt[i].s, vt[i].f, vt[i].l, vt[i].per, vt[i].e, vt[i].rdy);
            step();
            chk($sformatf("vec%0d.state", i), state, vt[i].exp_state);
            chk($sformatf("vec%0d.succ", i), succ_cnt, vt[i].exp_succ);
            chk($sformatf("vec%0d.fail", i), fail_cnt, vt[i].exp_fail);
            chk($sformatf("vec%0d.vv", i), verdict_valid, vt[i].exp_vv);
            chk($sformatf("vec%0d.verdict", i), verdict, vt[i].exp_verdict);
        end

        // Failures at periods 3, 7, 9 with the log held, then drained.
        drive(1, 0, 0, 0, 0, 0, 0, 0); step();
        drive(1, 1, 0, 1, 0, 8'd3, 0, 0); step();
        drive(1, 1, 0, 1, 0, 8'd7, 0, 0); step();
        drive(1, 1, 0, 1, 0, 8'd9, 0, 0); step();
        drive(1, 0, 0, 0, 0, 0, 1, 0); step();
        chk("ff3.fail_cnt", fail_cnt, STOP ? 1 : 3);
        chk("ff3.first_fail", {first_fail_valid, first_fail_period}, {1'b1, 8'd3});
        chk("ff3.state", state, 2);
        chk("ff3.verdict", verdict, 2'b01);
        exp_log = STOP ? '{8'd3} : '{8'd3, 8'd7, 8'd9};
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        foreach (exp_log[k]) begin
            chk($sformatf("drain%0d.valid", k), bus.log_valid, 1'b1);
            chk($sformatf("drain%0d.period", k), bus.log_period, exp_log[k]);
            step();
        end
        chk("drain.empty", bus.log_valid, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();

`ifndef SVA_STOP_ON_FAIL_EN
        // Overflow: ten failures into an eight-entry log, then push+pop while full.
        drive(1, 0, 0, 0, 0, 0, 0, 0); step();
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 0, 1, 0, 8'h10 + 8'(i), 0, 0);
            step();
            if (i == 7) chk("ovf.before", log_overflow, 1'b0);
            if (i == 8) chk("ovf.after", log_overflow, 1'b1);
        end
        chk("ovf.fail_cnt", fail_cnt, 10);
        chk("ovf.head", bus.log_period, 8'h10);
        drive(1, 1, 0, 1, 0, 8'h55, 0, 1); step();
        chk("full_pp.head", bus.log_period, 8'h11);
        chk("full_pp.fail_cnt", fail_cnt, 11);
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("full_drain%0d", k), {bus.log_valid, bus.log_period},
                {1'b1, (k == 7) ? 8'h55 : 8'h11 + 8'(k)});
            step();
        end
        chk("full_drain.empty", bus.log_valid, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();
`else
        // Stop on first failure: four successes, a failure, then more successes.
        drive(1, 0, 0, 0, 0, 0, 0, 0); step();
        for (int i = 0; i < 4; i++) begin drive(1, 1, 1, 0, 0, 0, 0, 0); step(); end
        drive(1, 1, 0, 1, 0, 8'h42, 0, 0); step();
        chk("stop.state", state, 2);
        chk("stop.vv", verdict_valid, 1'b1);
        for (int i = 0; i < 3; i++) begin drive(1, 1, 1, 0, 0, 0, 0, 0); step(); end
        chk("stop.succ_cnt", succ_cnt, 4);
        chk("stop.fail_cnt", fail_cnt, 1);
        chk("stop.verdict", verdict, 2'b01);
        drive(0, 0, 0, 0, 0, 0, 0, 1); step();
`endif

        // Success and failure in the same bundle.
        drive(1, 0, 0, 0, 0, 0, 0, 1); step();
        chk("proto.clear", proto_err, 1'b0);
        drive(1, 1, 1, 1, 0, 8'h21, 0, 1); step();
        chk("proto.flag", proto_err, 1'b1);
        chk("proto.counts", {succ_cnt, fail_cnt}, {16'd1, 16'd1});
        drive(1, 0, 0, 0, 0, 0, 1, 1); step();
        drive(0, 0, 0, 0, 0, 0, 0, 1); step();

        // Saturation on the narrow-counter instance.
        drive(1, 0, 0, 0, 0, 0, 0, 0); step();
        for (int i = 0; i < 20; i++) begin drive(1, 1, 1, 0, 0, 0, 0, 0); step(); end
        chk("sat.w4", succ_cnt4, 4'd15);
        chk("sat.w16", succ_cnt, 16'd20);
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();

        // Asynchronous reset in the middle of a run.
        drive(1, 0, 0, 0, 0, 0, 0, 0); step();
        for (int i = 0; i < 3; i++) begin drive(1, 1, 1, 1, 1, 8'h44, 0, 0); step(); end
        #3 grst = 1'b1;
        #1;
        chk("arst.state", state, 0);
        chk("arst.counts", {succ_cnt, fail_cnt, lazy_cnt}, 0);
        chk("arst.first_fail", {first_fail_valid, first_fail_period}, 0);
        chk("arst.flags", {log_overflow, proto_err, bus.log_valid, verdict_valid, verdict}, 0);
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        grst = 1'b0;
        step();

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            drive($urandom_range(0, 99) < 92, $urandom_range(0, 99) < 60,
                  1'($urandom), $urandom_range(0, 99) < 30, 1'($urandom),
                  TW'($urandom), $urandom_range(0, 99) < 4, 1'($urandom));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
